round_robin_mux_arbiter: RTL and testbench
==========================================

# round_robin_mux_arbiter

Two-input round-robin arbiter with a registered 2:1 data mux on its output, used in front of single-consumer datapaths. It accepts words from two valid/ready source channels, alternates fairly between them when both request, and presents one word per cycle on a registered output channel together with the select bit identifying its source. Internally it computes the select that steers a 2:1 mux and captures the muxed word into a one-entry output buffer.

## Interface
- WIDTH, 8, data width of both source channels and of the output.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  source A has a word.
- a_data  input  WIDTH  source A word.
- a_ready  output  1  source A word accepted this cycle when high with a_valid.
- b_valid  input  1  source B has a word.
- b_data  input  WIDTH  source B word.
- b_ready  output  1  source B word accepted this cycle when high with b_valid.
- out_valid  output  1  output buffer holds a word.
- out_data  output  WIDTH  buffered word.
- out_sel  output  1  source of buffered word: 0 = A, 1 = B.
- out_ready  input  1  consumer takes the buffered word when high with out_valid.

## Operation
- State: output buffer (out_valid, out_data, out_sel) and priority pointer `last` (source granted most recently).
- can_accept = !out_valid || out_ready (buffer empty or being drained this cycle).
- Grant, combinational:
  - only a_valid → grant A; only b_valid → grant B.
  - both valid → grant the source not equal to `last` (A if last = B, B if last = A).
  - neither → no grant.
- a_ready = can_accept && grant == A; b_ready = can_accept && grant == B. At most one ready high per cycle. Ready is 0 for a source that is not granted, even if it is valid.
- Readies depend combinationally on out_ready and on both valids; sources must not make valid depend on ready.
- On transfer (selected valid && ready): out_data ← muxed word (sel ? b_data : a_data), out_sel ← grant, out_valid ← 1, last ← grant.
- On drain without new transfer (out_valid && out_ready, no grant): out_valid ← 0; out_data and out_sel keep their old values.
- Simultaneous drain and transfer: the buffer is overwritten with the new word, and out_valid stays 1. This gives full throughput of one word per cycle.
- Backpressure (out_valid && !out_ready): out_valid, out_data and out_sel are held stable. Both readies are 0. `last` does not change.
- `last` changes only on a transfer. A single requester keeps its grant without alternation.

## Timing
- Reset values, applied immediately on rst assertion: out_valid = 0, out_data = 0, out_sel = 0, last = B. With last = B, the first contended grant goes to A.
- Latency: a word accepted in cycle N appears on out_data with out_valid = 1 from cycle N+1.
- Throughput: 1 word/cycle while out_ready stays high. Under continuous dual requests the grant sequence is A, B, A, B, …
- Reset during operation: the buffered word is discarded, out_valid drops asynchronously, and `last` returns to B. Readies are 0 while rst is high.
- Fairness bound: while a source keeps valid asserted, it waits at most one accepted word from the other source.

## Test plan
- Reset then idle: assert rst with random inputs → out_valid = 0, out_data = 0, out_sel = 0, a_ready = b_ready = 0. After release with no valids, out_valid stays 0.
- Single source: a_valid = 1 with data 0x11, 0x22, 0x33 on consecutive cycles, out_ready = 1 → out_data = 0x11, 0x22, 0x33 on the following cycles, out_sel = 0, b_ready = 0 throughout.
- Contention: a_valid = b_valid = 1 held, a_data = 0xA0, b_data = 0xB0, out_ready = 1 → out_sel sequence 0, 1, 0, 1 with matching out_data 0xA0, 0xB0, 0xA0, 0xB0.
- Backpressure: fill the buffer with 0x5C from B, then drive out_ready = 0 for 3 cycles with both sources valid → out_data = 0x5C and out_sel = 1 are held, both readies are 0. When out_ready rises, A (0xA0) is granted in that same cycle.
- Drain-and-refill edge: out_valid = 1, out_ready = 1, b_valid = 1 with 0x7E in the same cycle → next cycle out_valid = 1, out_data = 0x7E, out_sel = 1, with no bubble.
- Reset mid-stream: during contended streaming, pulse rst for a partial cycle → out_valid drops at once. After release, the first contended grant is A (out_sel = 0).

Source files
------------

// File: rtl/round_robin_mux_arbiter.sv
// Two-source round-robin arbiter feeding a registered 2:1 mux into a one-entry output buffer.
// out_sel reports the source of the buffered word (0 = A, 1 = B).
module round_robin_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a_valid,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_b_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_sel,
  input  logic             i_out_ready
);

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sel;
  logic             r_last;

  logic             w_can_accept;
  logic             w_grant_valid;
  logic             w_grant_sel;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_data;

  // Reset gating keeps both readies low while i_rst is high.
  assign w_can_accept = (!r_out_valid || i_out_ready) && !i_rst;

  // Grant selection: contended requests go to the source not granted last.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_sel   = SRC_A;
    if (i_a_valid && i_b_valid) begin
      w_grant_valid = 1'b1;
      w_grant_sel   = ~r_last;
    end else if (i_a_valid) begin
      w_grant_valid = 1'b1;
      w_grant_sel   = SRC_A;
    end else if (i_b_valid) begin
      w_grant_valid = 1'b1;
      w_grant_sel   = SRC_B;
    end else begin
      w_grant_valid = 1'b0;
      w_grant_sel   = SRC_A;
    end
  end

  assign w_xfer     = w_grant_valid && w_can_accept;
  assign w_mux_data = (w_grant_sel == SRC_B) ? i_b_data : i_a_data;
  assign o_a_ready  = w_xfer && (w_grant_sel == SRC_A);
  assign o_b_ready  = w_xfer && (w_grant_sel == SRC_B);

  // Output buffer and priority pointer; drain without refill only clears valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
      r_out_sel   <= SRC_A;
      r_last      <= SRC_B;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_sel   <= w_grant_sel;
      r_last      <= w_grant_sel;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Randomized and directed bench for round_robin_mux_arbiter against a least-recently-granted model.
module tb_round_robin_mux_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, out_sel;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: buffer contents plus the cycle at which each source was last granted.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_sel;
  int           m_t[2];
  int           cyc = 0;

  round_robin_mux_arbiter #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_sel(out_sel),
    .i_out_ready(out_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 1'b0;
    m_t[0]  = -2;
    m_t[1]  = -1;
  endtask

  // One cycle: drive inputs, check readies, clock, then check the buffer.
  task automatic drive(input logic av, input logic [W-1:0] ad, input logic bv,
                       input logic [W-1:0] bd, input logic ordy);
    logic can;
    logic req[2];
    int   win;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
    req[0] = av;
    req[1] = bv;
    can = !m_valid || ordy;
    win = -1;
    for (int s = 0; s < 2; s++)
      if (req[s] && (win < 0 || m_t[s] < m_t[win])) win = s;
    if (!can) win = -1;
    check("a_ready", {31'd0, a_ready}, {31'd0, win == 0});
    check("b_ready", {31'd0, b_ready}, {31'd0, win == 1});
    @(posedge clk);
    cyc++;
    if (win >= 0) begin
      m_valid = 1'b1;
      m_data  = (win == 1) ? bd : ad;
      m_sel   = (win == 1);
      m_t[win] = cyc;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data", {24'd0, out_data}, {24'd0, m_data});
    check("out_sel", {31'd0, out_sel}, {31'd0, m_sel});
  endtask

  logic [7:0] seq_data[4];

  initial begin
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'($urandom); b_valid = 1'($urandom); out_ready = 1'($urandom);
      a_data = 8'($urandom); b_data = 8'($urandom);
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_out_sel", {31'd0, out_sel}, 32'd0);
      check("rst_a_ready", {31'd0, a_ready}, 32'd0);
      check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Contention: A first after reset, then alternating
    seq_data[0] = 8'hA0; seq_data[1] = 8'hB0; seq_data[2] = 8'hA0; seq_data[3] = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
      check("cont_sel", {31'd0, out_sel}, 32'(i % 2));
      check("cont_data", {24'd0, out_data}, {24'd0, seq_data[i]});
    end

    // Single source A stream
    seq_data[0] = 8'h11; seq_data[1] = 8'h22; seq_data[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, seq_data[i], 1'b0, 8'hEE, 1'b1);
      check("single_data", {24'd0, out_data}, {24'd0, seq_data[i]});
      check("single_sel", {31'd0, out_sel}, 32'd0);
    end

    // Backpressure holds the B word, then A wins when released
    drive(1'b0, 8'h00, 1'b1, 8'h5C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hA0, 1'b1, 8'hB1, 1'b0);
      check("bp_data", {24'd0, out_data}, 32'h5C);
      check("bp_sel", {31'd0, out_sel}, 32'd1);
    end
    drive(1'b1, 8'hA0, 1'b1, 8'hB1, 1'b1);
    check("bp_release_data", {24'd0, out_data}, 32'hA0);
    check("bp_release_sel", {31'd0, out_sel}, 32'd0);

    // Drain and refill in the same cycle
    drive(1'b0, 8'h00, 1'b1, 8'h7E, 1'b1);
    check("refill_valid", {31'd0, out_valid}, 32'd1);
    check("refill_data", {24'd0, out_data}, 32'h7E);
    check("refill_sel", {31'd0, out_sel}, 32'd1);

    // Reset pulse mid-stream
    drive(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);
    drive(1'b1, 8'hA3, 1'b1, 8'hB4, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_a_ready", {31'd0, a_ready}, 32'd0);
    check("midrst_b_ready", {31'd0, b_ready}, 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1'b1, 8'hA5, 1'b1, 8'hB6, 1'b1);
    check("midrst_first_sel", {31'd0, out_sel}, 32'd0);
    check("midrst_first_data", {24'd0, out_data}, 32'hA5);

    // Random traffic
    for (int i = 0; i < 400; i++)
      drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
